// File: rtl/hazard_interlock_unit.sv
// rtl/hazard_interlock_unit.sv - decode-side RAW interlock with shadow destination slots
module hazard_interlock_unit #(
    parameter int PIPE_DEPTH = 3,
    parameter bit WB_BYPASS  = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid_in,
    input  logic [4:0]       dec_rs1_addr_in,
    input  logic             dec_rs1_used_in,
    input  logic [4:0]       dec_rs2_addr_in,
    input  logic             dec_rs2_used_in,
    input  logic [4:0]       dec_rd_addr_in,
    input  logic             dec_rd_write_in,
    input  logic             branch_kill_in,
    output logic             stall_out,
    output logic             bubble_out,
    output logic             issue_out,
    output logic [31:0]      pending_mask_out,
    output logic [CNT_W-1:0] stall_count_out
);

    // With write-back bypass the register file already sees the RW write, so the oldest slot is skipped.
    localparam int NCHK = WB_BYPASS ? PIPE_DEPTH - 1 : PIPE_DEPTH;

    logic [PIPE_DEPTH-1:0] slot_valid;
    logic [4:0]            slot_rd [PIPE_DEPTH];
    logic                  rs1_hit;
    logic                  rs2_hit;
    logic                  hazard;
    logic [31:0]           pending;

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < NCHK; i++) begin
            if (slot_valid[i] && (slot_rd[i] == dec_rs1_addr_in)) rs1_hit = 1'b1;
            if (slot_valid[i] && (slot_rd[i] == dec_rs2_addr_in)) rs2_hit = 1'b1;
        end
        hazard = dec_valid_in &
                 ((dec_rs1_used_in & (|dec_rs1_addr_in) & rs1_hit) |
                  (dec_rs2_used_in & (|dec_rs2_addr_in) & rs2_hit));
    end

    always_comb begin
        stall_out  = 1'b0;
        bubble_out = 1'b1;
        issue_out  = 1'b0;
        if (!rst && !branch_kill_in) begin
            if (hazard) begin
                stall_out = 1'b1;
            end else begin
                issue_out  = dec_valid_in;
                bubble_out = ~dec_valid_in;
            end
        end
    end

    // Kill only suppresses the new entry; older slots belong to instructions that still complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) slot_rd[i] <= 5'd0;
        end else begin
            slot_valid <= {slot_valid[PIPE_DEPTH-2:0],
                           issue_out & dec_rd_write_in & (|dec_rd_addr_in)};
            slot_rd[0] <= dec_rd_addr_in;
            for (int i = 1; i < PIPE_DEPTH; i++) slot_rd[i] <= slot_rd[i-1];
        end
    end

    always_comb begin
        pending = 32'd0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (slot_valid[i]) pending[slot_rd[i]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign pending_mask_out = pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_out <= '0;
        end else if (stall_out && (stall_count_out != '1)) begin
            stall_count_out <= stall_count_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_interlock_unit.sv
// tb/tb_hazard_interlock_unit.sv - scoreboard bench for hazard_interlock_unit
module tb_hazard_interlock_unit;

    logic       clk = 1'b0;
    logic       rst, dv, u1, u2, wr, kill;
    logic [4:0] r1, r2, rd;

    logic        st [3];
    logic        bu [3];
    logic        is [3];
    logic [31:0] pm [3];
    logic [15:0] sc0, sc1;
    logic [3:0]  sc2;

    typedef struct {
        int          dut;
        logic        s;
        logic        b;
        logic        i;
        logic [31:0] mask;
        int          cnt;
        bit          cm;
        bit          cc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] B5 = 32'h0000_0020;

    always #5 clk = ~clk;

    hazard_interlock_unit #(.PIPE_DEPTH(3), .WB_BYPASS(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .dec_valid_in(dv),
        .dec_rs1_addr_in(r1), .dec_rs1_used_in(u1),
        .dec_rs2_addr_in(r2), .dec_rs2_used_in(u2),
        .dec_rd_addr_in(rd), .dec_rd_write_in(wr), .branch_kill_in(kill),
        .stall_out(st[0]), .bubble_out(bu[0]), .issue_out(is[0]),
        .pending_mask_out(pm[0]), .stall_count_out(sc0));

    hazard_interlock_unit #(.PIPE_DEPTH(3), .WB_BYPASS(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .dec_valid_in(dv),
        .dec_rs1_addr_in(r1), .dec_rs1_used_in(u1),
        .dec_rs2_addr_in(r2), .dec_rs2_used_in(u2),
        .dec_rd_addr_in(rd), .dec_rd_write_in(wr), .branch_kill_in(kill),
        .stall_out(st[1]), .bubble_out(bu[1]), .issue_out(is[1]),
        .pending_mask_out(pm[1]), .stall_count_out(sc1));

    hazard_interlock_unit #(.PIPE_DEPTH(3), .WB_BYPASS(1'b0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .dec_valid_in(dv),
        .dec_rs1_addr_in(r1), .dec_rs1_used_in(u1),
        .dec_rs2_addr_in(r2), .dec_rs2_used_in(u2),
        .dec_rd_addr_in(rd), .dec_rd_write_in(wr), .branch_kill_in(kill),
        .stall_out(st[2]), .bubble_out(bu[2]), .issue_out(is[2]),
        .pending_mask_out(pm[2]), .stall_count_out(sc2));

    task automatic drive(input logic r, input logic v, input logic [4:0] a1, input logic e1,
                         input logic [4:0] a2, input logic e2, input logic [4:0] d,
                         input logic w, input logic k);
        @(posedge clk);
        #1;
        rst = r; dv = v; r1 = a1; u1 = e1; r2 = a2; u2 = e2; rd = d; wr = w; kill = k;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic expect1(input int d, input logic s, input logic b, input logic i,
                           input logic [31:0] mask, input int cnt, input bit cm, input bit cc,
                           input string name);
        exp_t e;
        e.dut = d; e.s = s; e.b = b; e.i = i; e.mask = mask; e.cnt = cnt;
        e.cm = cm; e.cc = cc; e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_all(input logic s, input logic b, input logic i, input logic [31:0] mask,
                              input bit cm, input int c0, input int c1, input int c2,
                              input bit cc, input string name);
        expect1(0, s, b, i, mask, c0, cm, cc, name);
        expect1(1, s, b, i, mask, c1, cm, cc, name);
        expect1(2, s, b, i, mask, c2, cm, cc, name);
    endtask

    task automatic cmp(input string name, input int d, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", name, d, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            int   cnt;
            e = sb.pop_front();
            cnt = (e.dut == 0) ? int'(sc0) : (e.dut == 1) ? int'(sc1) : int'(sc2);
            cmp({e.name, ".stall"},  e.dut, int'(st[e.dut]), int'(e.s));
            cmp({e.name, ".bubble"}, e.dut, int'(bu[e.dut]), int'(e.b));
            cmp({e.name, ".issue"},  e.dut, int'(is[e.dut]), int'(e.i));
            if (e.cm) cmp({e.name, ".mask"},  e.dut, int'(pm[e.dut]), int'(e.mask));
            if (e.cc) cmp({e.name, ".count"}, e.dut, cnt, e.cnt);
        end
    end

    initial begin
        int  c0, c1, c2;
        bit  s0, s1;
        rst = 1'b1; dv = 1'b0; r1 = '0; u1 = 1'b0; r2 = '0; u2 = 1'b0; rd = '0; wr = 1'b0; kill = 1'b0;

        // Reset with a valid, hazard-looking decode present
        drive(1, 1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 0); expect_all(0, 1, 0, 0, 0, 0, 0, 0, 0, "rst1");
        drive(1, 1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 0); expect_all(0, 1, 0, 0, 1, 0, 0, 0, 1, "rst2");

        // RAW on x5: 3 stalls without bypass, 2 with bypass
        drive(0, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0); expect_all(0, 0, 1, 0, 1, 0, 0, 0, 1, "raw_a");
        drive(0, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0); expect_all(1, 1, 0, B5, 1, 0, 0, 0, 1, "raw_b1");
        drive(0, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0); expect_all(1, 1, 0, B5, 1, 1, 1, 1, 1, "raw_b2");
        drive(0, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0);
        expect1(0, 1, 1, 0, B5, 2, 1, 1, "raw_b3");
        expect1(1, 0, 0, 1, B5, 2, 1, 1, "raw_b3");
        expect1(2, 1, 1, 0, B5, 2, 1, 1, "raw_b3");
        drive(0, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0); expect_all(0, 0, 1, 0, 1, 3, 2, 3, 1, "raw_b4");
        idle();                                    expect_all(0, 1, 0, 0, 1, 3, 2, 3, 1, "raw_idle");

        // x0 never pends; unused rs2 ignores a pending match
        drive(0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0); expect_all(0, 0, 1, 0, 1, 3, 2, 3, 1, "x0_c1");
        drive(0, 1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0); expect_all(0, 0, 1, 0, 1, 3, 2, 3, 1, "x0_c2");
        drive(0, 1, 5'd0, 1, 5'd5, 0, 5'd0, 0, 0); expect_all(0, 0, 1, B5, 1, 3, 2, 3, 1, "x0_c3");
        idle();                                    expect_all(0, 1, 0, B5, 1, 3, 2, 3, 1, "x0_c4");
        idle();                                    expect_all(0, 1, 0, B5, 1, 3, 2, 3, 1, "x0_c5");
        idle();                                    expect_all(0, 1, 0, 0, 1, 3, 2, 3, 1, "x0_c6");

        // Kill dominates a hazard; slot0 not loaded, older slots kept
        drive(0, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0); expect_all(0, 0, 1, 0, 1, 3, 2, 3, 1, "kill_d1");
        drive(0, 1, 5'd5, 1, 5'd0, 0, 5'd9, 1, 1); expect_all(0, 1, 0, B5, 1, 3, 2, 3, 1, "kill_d2");
        drive(0, 1, 5'd5, 1, 5'd0, 0, 5'd9, 1, 0); expect_all(1, 1, 0, B5, 1, 3, 2, 3, 1, "kill_d3");
        drive(0, 1, 5'd5, 1, 5'd0, 0, 5'd9, 1, 1); expect_all(0, 1, 0, B5, 1, 4, 3, 4, 1, "kill_d4");
        idle();                                    expect_all(0, 1, 0, 0, 1, 4, 3, 4, 1, "kill_d5");

        // Self-dependent writer of x5 held for 28 cycles: counter saturation on the 4-bit instance
        drive(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0); expect_all(0, 1, 0, 0, 0, 0, 0, 0, 0, "sat_rst");
        for (int e = 0; e < 28; e++) begin
            drive(0, 1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0);
            c0 = e - (e + 3) / 4;
            c1 = e - (e + 2) / 3;
            c2 = (c0 > 15) ? 15 : c0;
            s0 = (e % 4) != 0;
            s1 = (e % 3) != 0;
            expect1(0, s0, s0, !s0, (e % 4 == 0) ? 32'd0 : B5, c0, 1, 1, "sat_loop");
            expect1(1, s1, s1, !s1, (e == 0) ? 32'd0 : B5, c1, 1, 1, "sat_loop");
            expect1(2, s0, s0, !s0, (e % 4 == 0) ? 32'd0 : B5, c2, 1, 1, "sat_loop");
        end

        // Reset while stalled
        drive(1, 1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0); expect_all(0, 1, 0, 0, 0, 21, 18, 15, 1, "rst_mid");
        idle();                                    expect_all(0, 1, 0, 0, 1, 0, 0, 0, 1, "rst_after");

        idle();
        for (int t = 0; t < 5; t++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
